audio_i2s_tx: RTL
=================

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per BCLK half-period, legal range 2..255.
REQ-002 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port enable  input  1  1 runs the transmitter; 0 idles it.
REQ-005 Port in_sample  input  16  signed mono sample from the processing chain output.
REQ-006 Port in_valid  input  1  in_sample is valid this cycle.
REQ-007 Port in_ready  output  1  holding register can accept a sample.
REQ-008 Port underrun_clr  input  1  clears the underrun flag.
REQ-009 Port i2s_bclk  output  1  I2S bit clock.
REQ-010 Port i2s_lrclk  output  1  I2S word select: 0 is left, 1 is right.
REQ-011 Port i2s_sdata  output  1  I2S serial data.
REQ-012 Port underrun  output  1  sticky flag: a frame started with no sample available.

Function
REQ-013 Divider counts 0..CLK_DIV-1 while enabled; i2s_bclk SHALL toggle on the cycle the count equals CLK_DIV-1, then the counter wraps to 0.
REQ-014 A 6-bit bit counter (0..63) SHALL advance on every BCLK falling edge and wrap 63->0; one frame is 64 BCLK periods.
REQ-015 i2s_lrclk SHALL be 0 for bit counts 0..31 and 1 for bit counts 32..63, updated on the same falling edge as the bit counter.
REQ-016 i2s_sdata SHALL change only on BCLK falling edges, MSB first: frame bits 15..0 at bit counts 1..16 (left) and 33..48 (right); 0 at all other counts (I2S one-bit delay).
REQ-017 Mono duplication: left and right slots SHALL carry the same 16-bit frame word.
REQ-018 Holding register is one entry; in_ready = enable & ~holding_full, registered, with no combinational path from in_valid.
REQ-019 Accept when in_valid & in_ready; holding_full sets on the next edge.
REQ-020 At the falling edge that wraps the bit counter to 0, the frame word SHALL load from holding if full, and holding_full SHALL clear.
REQ-021 Underrun: if holding is empty at the REQ-020 edge, the frame word SHALL take the underrun value (see Configuration) and underrun SHALL set.
REQ-022 Simultaneous accept and frame load with holding empty: the new sample goes to holding for the next frame, and the current frame is an underrun.
REQ-023 underrun_clr clears the flag; if set and clear occur in the same cycle, set wins.
REQ-024 enable low: divider and bit counter SHALL go to 0, i2s_bclk/i2s_lrclk/i2s_sdata SHALL be 0, holding SHALL be flushed, in_ready SHALL be 0, and underrun SHALL be retained.
REQ-025 On enable rising: the first BCLK rising edge SHALL occur CLK_DIV cycles later, and the first frame SHALL start at bit count 0 with frame word 0 and no underrun flagged.

Reset
REQ-026 rst high SHALL immediately force i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, in_ready=0, underrun=0, all counters 0, holding empty, and frame word 0.
REQ-027 Reset mid-frame SHALL abort the frame; after rst falls, operation SHALL resume per REQ-025 if enable is high.

Configuration
REQ-028 Macro AUDIO_I2S_TX_UNDERRUN_HOLD_EN defined: the underrun frame word SHALL repeat the previous frame word.
REQ-029 Macro AUDIO_I2S_TX_UNDERRUN_HOLD_EN undefined: the underrun frame word SHALL be 16'sd0.
REQ-030 The underrun flag behaviour SHALL be identical in both builds.

Verification (CLK_DIV=2, so one frame is 256 clk cycles)
REQ-031 Push 16'sh8001 before frame 1 -> left bits count 1..16 read 1000000000000001, right slot identical, all other bits 0, lrclk low for 128 clk.
REQ-032 Hold in_valid high with 16'sh1234 -> in_ready drops one cycle after accept, rises one cycle after each frame load, and one sample is consumed per frame.
REQ-033 Send 16'sh7FFF, then no sample for the next frame -> underrun=1; frame 2 carries 16'sh7FFF with the macro defined and 16'sh0000 without it.
REQ-034 Assert underrun_clr in the same cycle as a new underrun -> underrun stays 1; assert it alone -> underrun goes 0 on the next edge.
REQ-035 Assert rst at bit count 20 -> all outputs 0 immediately; after release, the first BCLK rising edge comes 2 clk later.
REQ-036 Drop enable at bit count 40 for 10 cycles with holding full -> outputs 0, holding flushed, underrun unchanged, frame restarts at bit count 0.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: one-entry holding register feeding a 64-bit-clock stereo frame, mono sample duplicated left/right.
// Build option AUDIO_I2S_TX_UNDERRUN_HOLD_EN: an underrun frame repeats the previous word instead of sending silence.
module audio_i2s_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic signed [15:0] in_sample,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               underrun_clr,
  output logic               i2s_bclk,
  output logic               i2s_lrclk,
  output logic               i2s_sdata,
  output logic               underrun
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [15:0] frame_word;
  logic [15:0] holding;
  logic        holding_full;
  logic        ready_q;
  logic        bclk_q;
  logic        lrclk_q;
  logic        sdata_q;
  logic        underrun_q;

  logic        div_wrap;
  logic        bclk_fall;
  logic        frame_load;
  logic        accept;
  logic        underrun_set;
  logic        full_next;
  logic [5:0]  bit_next;
  logic [15:0] underrun_word;
  logic [15:0] word_next;
  logic [3:0]  sdata_idx;
  logic        sdata_next;

  always_comb begin
    div_wrap     = enable && (div_cnt == DIV_LAST);
    bclk_fall    = div_wrap && bclk_q;
    frame_load   = bclk_fall && (bit_cnt == 6'd63);
    accept       = in_valid && in_ready;
    underrun_set = frame_load && !holding_full;
    // Holding frees on a frame load; a simultaneous accept (only possible when empty) refills it.
    full_next    = (holding_full && !frame_load) || accept;
    bit_next     = bit_cnt + 6'd1;
`ifdef AUDIO_I2S_TX_UNDERRUN_HOLD_EN
    underrun_word = frame_word;
`else
    underrun_word = 16'd0;
`endif
    word_next = frame_word;
    if (frame_load) begin
      word_next = holding_full ? holding : underrun_word;
    end
  end

  // One-bit I2S delay: slot bit 0 is idle, MSB goes out on bit 1 (left) / 33 (right).
  always_comb begin
    sdata_idx  = 4'd0;
    sdata_next = 1'b0;
    if ((bit_next >= 6'd1) && (bit_next <= 6'd16)) begin
      sdata_idx  = 4'(6'd16 - bit_next);
      sdata_next = frame_word[sdata_idx];
    end else if ((bit_next >= 6'd33) && (bit_next <= 6'd48)) begin
      sdata_idx  = 4'(6'd48 - bit_next);
      sdata_next = frame_word[sdata_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt      <= 8'd0;
      bclk_q       <= 1'b0;
      bit_cnt      <= 6'd0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      frame_word   <= 16'd0;
      holding      <= 16'd0;
      holding_full <= 1'b0;
      ready_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else if (!enable) begin
      // Idle: frame word zeroed so the next enable starts with a silent, unflagged frame.
      div_cnt      <= 8'd0;
      bclk_q       <= 1'b0;
      bit_cnt      <= 6'd0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      frame_word   <= 16'd0;
      holding_full <= 1'b0;
      ready_q      <= 1'b0;
      underrun_q   <= underrun_q && !underrun_clr;
    end else begin
      div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
      if (div_wrap) begin
        bclk_q <= !bclk_q;
      end
      if (bclk_fall) begin
        bit_cnt <= bit_next;
        lrclk_q <= bit_next[5];
        sdata_q <= sdata_next;
      end
      frame_word <= word_next;
      if (accept) begin
        holding <= in_sample;
      end
      holding_full <= full_next;
      ready_q      <= !full_next;
      underrun_q   <= underrun_set || (underrun_q && !underrun_clr);
    end
  end

  // Gated by enable so a disable is seen the same cycle; in_valid never reaches in_ready.
  assign in_ready  = ready_q && enable;
  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sdata = sdata_q;
  assign underrun  = underrun_q;

endmodule
